// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: request/response initiator for an NREG x WIDTH register-file cell array.
// Optional feature macro RF_FAST_READ_EN: read-only requests skip the WRITE state.
module rf_access_ctrl #(
  parameter int NREG  = 8,
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_waddr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [AW-1:0]    req_raddr_a,
  input  logic [AW-1:0]    req_raddr_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data_a,
  output logic [WIDTH-1:0] rsp_data_b,
  output logic             rsp_err,
  output logic [NREG-1:0]  W,
  output logic [WIDTH-1:0] I,
  output logic [NREG-1:0]  Ra,
  output logic [NREG-1:0]  Rb,
  input  logic [WIDTH-1:0] Oa,
  input  logic [WIDTH-1:0] Ob,
  output logic [1:0]       fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and response fields hold while rsp_valid waits.
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, RESP = 2'd3} state_t;

  localparam logic [AW:0]     NREG_LIM = (AW + 1)'(NREG);
  localparam logic [NREG-1:0] ONE      = {{(NREG - 1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             we_q;
  logic [AW-1:0]    waddr_q, raddr_a_q, raddr_b_q;
  logic [WIDTH-1:0] wdata_q;
  logic             wa_ok, ra_ok, rb_ok, err_c;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < NREG_LIM);
  endfunction

  assign wa_ok     = we_q & in_range(waddr_q);
  assign ra_ok     = in_range(raddr_a_q);
  assign rb_ok     = in_range(raddr_b_q);
  assign err_c     = (we_q & ~in_range(waddr_q)) | ~ra_ok | ~rb_ok;
  assign fsm_state = state_q;

  // Cell strobes are gated by Rst so a reset edge can never commit a write.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    W         = '0;
    I         = '0;
    Ra        = '0;
    Rb        = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
`ifdef RF_FAST_READ_EN
          state_d = req_we ? WRITE : READ;
`else
          state_d = WRITE;
`endif
        end
      end
      WRITE: begin
        if (!Rst) begin
          I = wdata_q;
          if (wa_ok) W = ONE << waddr_q;
        end
        state_d = READ;
      end
      READ: begin
        if (!Rst) begin
          if (ra_ok) Ra = ONE << raddr_a_q;
          if (rb_ok) Rb = ONE << raddr_b_q;
        end
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      raddr_a_q  <= '0;
      raddr_b_q  <= '0;
      rsp_data_a <= '0;
      rsp_data_b <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        we_q      <= req_we;
        waddr_q   <= req_waddr;
        wdata_q   <= req_wdata;
        raddr_a_q <= req_raddr_a;
        raddr_b_q <= req_raddr_b;
      end
      // An unselected port leaves its bus floating, so return zero instead of sampling it.
      if (state_q == READ) begin
        rsp_data_a <= ra_ok ? Oa : '0;
        rsp_data_b <= rb_ok ? Ob : '0;
        rsp_err    <= err_c;
      end
    end
  end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb_rf_access_ctrl: directed bench for rf_access_ctrl with a behavioural cell array (NREG=6).
module tb_rf_access_ctrl;

  localparam int NREG  = 6;
  localparam int WIDTH = 8;
  localparam int AW    = 3;
`ifdef RF_FAST_READ_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [AW-1:0]    req_waddr = '0, req_raddr_a = '0, req_raddr_b = '0;
  logic [WIDTH-1:0] req_wdata = '0;
  logic             rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [WIDTH-1:0] rsp_data_a, rsp_data_b;
  logic [NREG-1:0]  w, ra, rb;
  logic [WIDTH-1:0] i_bus, oa, ob;
  logic [1:0]       fsm_state;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  // ---------------- clock / cell array ----------------
  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [NREG] = '{default: 8'h00};
  always @(posedge clk) begin
    for (int k = 0; k < NREG; k++) if (w[k]) mem[k] <= i_bus;
  end

  // Undriven shared bus picks up junk so a stray sample is visible.
  always_comb begin
    oa = 8'hEE;
    ob = 8'hEE;
    for (int k = 0; k < NREG; k++) begin
      if (ra[k]) oa = mem[k];
      if (rb[k]) ob = mem[k];
    end
  end

  rf_access_ctrl #(.NREG(NREG), .WIDTH(WIDTH), .AW(AW)) dut (
    .Clk(clk), .Rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_waddr(req_waddr), .req_wdata(req_wdata),
    .req_raddr_a(req_raddr_a), .req_raddr_b(req_raddr_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b), .rsp_err(rsp_err),
    .W(w), .I(i_bus), .Ra(ra), .Rb(rb), .Oa(oa), .Ob(ob),
    .fsm_state(fsm_state)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("w_onehot0", 32'($onehot0(w)), 1);
      chk("w_rd_exclusive", 32'((w != '0) && ((ra | rb) != '0)), 0);
    end
  end

  // ---------------- driver ----------------
  int              lat, w_cycles;
  logic [NREG-1:0] w_seen, ra_seen, rb_seen;
  logic [WIDTH-1:0] i_seen, got_a, got_b;
  logic            got_err;

  task automatic send(input logic we_i, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                      input logic [AW-1:0] ra_i, input logic [AW-1:0] rb_i);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1; req_we = we_i; req_waddr = wa; req_wdata = wd;
    req_raddr_a = ra_i; req_raddr_b = rb_i;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    lat = 1; w_cycles = 0; w_seen = '0; ra_seen = '0; rb_seen = '0; i_seen = '0;
    while (!rsp_valid && lat < 12) begin
      chk("req_ready_busy", 32'(req_ready), 0);
      if (w != '0) begin w_cycles++; w_seen |= w; i_seen = i_bus; end
      ra_seen |= ra;
      rb_seen |= rb;
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_valid_arrives", 32'(rsp_valid), 1);
    got_a = rsp_data_a; got_b = rsp_data_b; got_err = rsp_err;
  endtask

  task automatic check_rsp(input string tag, input int exp_lat, input logic [WIDTH-1:0] exp_b,
                           input logic exp_err);
    logic [WIDTH-1:0] exp_a;
    exp_a = exp_q.pop_front();
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data_a"}, 32'(got_a), 32'(exp_a));
    chk({tag, "_data_b"}, 32'(got_b), 32'(exp_b));
    chk({tag, "_err"}, 32'(got_err), 32'(exp_err));
  endtask

  task automatic finish_rsp(input string tag);
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, 32'(rsp_valid), 0);
    chk({tag, "_ready_back"}, 32'(req_ready), 1);
  endtask

  // ---------------- directed sequence ----------------
  logic [WIDTH-1:0] snap [NREG];

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_w", 32'(w), 0);
    chk("rst_ra_rb", 32'(ra | rb), 0);
    chk("rst_i", 32'(i_bus), 0);
    chk("rst_data", 32'({rsp_data_a, rsp_data_b, 7'd0, rsp_err}), 0);
    rst = 1'b0;

    // write then read back the same address
    exp_q.push_back(8'hA5);
    send(1'b1, 3'd3, 8'hA5, 3'd3, 3'd0);
    chk("wr_w_cycles", 32'(w_cycles), 1);
    chk("wr_w_onehot", 32'(w_seen), 32'(6'b001000));
    chk("wr_i_bus", 32'(i_seen), 32'h0A5);
    check_rsp("wr", 3, 8'h00, 1'b0);
    finish_rsp("wr");

    // read-only, both ports on the same register
    exp_q.push_back(8'hA5);
    send(1'b0, 3'd0, 8'h00, 3'd3, 3'd3);
    chk("rd_w_cycles", 32'(w_cycles), 0);
    chk("rd_ra", 32'(ra_seen), 32'(6'b001000));
    chk("rd_rb", 32'(rb_seen), 32'(6'b001000));
    check_rsp("rd", RD_LAT, 8'hA5, 1'b0);
    finish_rsp("rd");

    // backpressure: response held for 5 cycles
    rsp_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send(1'b0, 3'd0, 8'h00, 3'd3, 3'd0);
    check_rsp("bp", RD_LAT, 8'h00, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_valid_hold", 32'(rsp_valid), 1);
      chk("bp_data_hold", 32'({rsp_data_a, rsp_data_b}), 32'h0A500);
      chk("bp_req_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    finish_rsp("bp");

    // highest valid address
    exp_q.push_back(8'h5A);
    send(1'b1, 3'd5, 8'h5A, 3'd5, 3'd3);
    chk("top_w", 32'(w_seen), 32'(6'b100000));
    check_rsp("top", 3, 8'hA5, 1'b0);
    finish_rsp("top");

    // out-of-range write and read-A
    for (int k = 0; k < NREG; k++) snap[k] = mem[k];
    exp_q.push_back(8'h00);
    send(1'b1, 3'd7, 8'h77, 3'd6, 3'd1);
    chk("oor_w_cycles", 32'(w_cycles), 0);
    chk("oor_ra", 32'(ra_seen), 0);
    chk("oor_rb", 32'(rb_seen), 32'(6'b000010));
    check_rsp("oor", 3, 8'h00, 1'b1);
    finish_rsp("oor");
    for (int k = 0; k < NREG; k++) chk("oor_mem_kept", 32'(mem[k]), 32'(snap[k]));

    // out-of-range on port B only
    exp_q.push_back(8'h00);
    send(1'b0, 3'd0, 8'h00, 3'd0, 3'd7);
    check_rsp("oorb", RD_LAT, 8'h00, 1'b1);
    finish_rsp("oorb");

    // reset in the middle of a WRITE
    exp_q.push_back(8'h3C);
    send(1'b1, 3'd2, 8'h3C, 3'd2, 3'd2);
    check_rsp("pre", 3, 8'h3C, 1'b0);
    finish_rsp("pre");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_waddr = 3'd2; req_wdata = 8'hFF;
    req_raddr_a = 3'd2; req_raddr_b = 3'd2;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_w", 32'(w), 0);
    chk("mid_rst_i", 32'(i_bus), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_state", 32'(fsm_state), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_mem2", 32'(mem[2]), 32'h03C);
    exp_q.push_back(8'h3C);
    send(1'b0, 3'd0, 8'h00, 3'd2, 3'd2);
    check_rsp("post", RD_LAT, 8'h3C, 1'b0);
    finish_rsp("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
